// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the fetch/LSU memory arbiter
package mem_pkg;

    localparam int MEM_DEPTH_DEFAULT = 2048;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_RMW_RD,
        ST_RMW_WR,
        ST_RESP
    } state_e;

    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_DATA  = 1'b1
    } req_e;

    function automatic logic [15:0] word_addr(input logic [31:0] addr);
        return addr[17:2];
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - little-endian load extract/extend and store lane merge
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_load,
    output logic [31:0] o_merge
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (i_offset)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];

        o_load = i_word;
        case (i_size)
            SZ_B:    o_load = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            SZ_H:    o_load = {{16{~i_unsigned & w_half[15]}}, w_half};
            default: o_load = i_word;
        endcase
    end

    // Only the addressed lanes take new data; the rest come from the old word.
    always_comb begin
        o_merge = i_word;
        case (i_size)
            SZ_B: begin
                case (i_offset)
                    2'd0:    o_merge[7:0]   = i_wdata[7:0];
                    2'd1:    o_merge[15:8]  = i_wdata[7:0];
                    2'd2:    o_merge[23:16] = i_wdata[7:0];
                    default: o_merge[31:24] = i_wdata[7:0];
                endcase
            end
            SZ_H: begin
                if (i_offset[1]) begin
                    o_merge[31:16] = i_wdata[15:0];
                end else begin
                    o_merge[15:0] = i_wdata[15:0];
                end
            end
            default: o_merge = i_wdata;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one word RAM between fetch and load/store, byte/half stores as RMW
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_addr,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,
    output logic        if_rsp_err,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic        d_unsigned,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_rsp_valid,
    output logic [31:0] d_rsp_data,
    output logic        d_rsp_err,
    output logic        ram_wen,
    output logic        ram_ren,
    output logic [1:0]  ram_ben,
    output logic [15:0] ram_waddr,
    output logic [15:0] ram_raddr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    localparam logic [31:0] DEPTH_W = 32'(MEM_DEPTH);

    state_e      r_state;
    state_e      w_state_nxt;
    req_e        r_last_grant;
    req_e        r_req;
    logic [15:0] r_word_addr;
    logic [1:0]  r_offset;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic        r_we;
    logic        r_err;
    logic [31:0] r_wdata;
    logic [31:0] r_if_data;
    logic [31:0] r_d_data;
    logic        r_if_err;
    logic        r_d_err;

    logic        w_grant_if;
    logic        w_grant_d;
    logic        w_accept;
    logic [31:0] w_sel_addr;
    logic [1:0]  w_sel_size;
    logic        w_sel_we;
    logic        w_range_err;
    logic        w_align_err;
    logic        w_sel_err;
    logic [31:0] w_load;
    logic [31:0] w_merge;
    logic [31:0] w_rsp_data;
    logic        w_rsp_fire;

    // Round-robin between the two requesters, only while idle and out of reset.
    always_comb begin
        w_grant_if = 1'b0;
        w_grant_d  = 1'b0;
        if (!rst && r_state == ST_IDLE) begin
            if (if_req_valid && d_req_valid) begin
                if (r_last_grant == REQ_FETCH) begin
                    w_grant_d = 1'b1;
                end else begin
                    w_grant_if = 1'b1;
                end
            end else begin
                w_grant_if = if_req_valid;
                w_grant_d  = d_req_valid;
            end
        end
    end

    assign if_req_ready = w_grant_if;
    assign d_req_ready  = w_grant_d;
    assign w_accept     = w_grant_if | w_grant_d;

    // A fetch is treated as an aligned word load.
    assign w_sel_addr  = w_grant_d ? d_addr : if_addr;
    assign w_sel_size  = w_grant_d ? d_size : SZ_W;
    assign w_sel_we    = w_grant_d & d_we;
    assign w_range_err = (|w_sel_addr[31:18]) || ({16'd0, word_addr(w_sel_addr)} >= DEPTH_W);

    always_comb begin
        w_align_err = 1'b1;
        case (w_sel_size)
            SZ_B:    w_align_err = 1'b0;
            SZ_H:    w_align_err = w_sel_addr[0];
            SZ_W:    w_align_err = |w_sel_addr[1:0];
            default: w_align_err = 1'b1;
        endcase
    end

    assign w_sel_err = w_range_err | w_align_err;

    mem_lane_align u_lane_align (
        .i_word     (ram_rdata),
        .i_wdata    (r_wdata),
        .i_offset   (r_offset),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_load     (w_load),
        .o_merge    (w_merge)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // RAM strobes are gated by rst so an RMW interrupted by reset never writes.
    always_comb begin
        w_state_nxt = r_state;
        ram_ren     = 1'b0;
        ram_wen     = 1'b0;
        ram_raddr   = 16'd0;
        ram_waddr   = 16'd0;
        ram_wdata   = 32'd0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_sel_err) begin
                        w_state_nxt = ST_RESP;
                    end else if (!w_sel_we) begin
                        w_state_nxt = ST_RD;
                    end else if (w_sel_size == SZ_W) begin
                        w_state_nxt = ST_WR;
                    end else begin
                        w_state_nxt = ST_RMW_RD;
                    end
                end
            end
            ST_RD: begin
                ram_ren     = !rst;
                ram_raddr   = r_word_addr;
                w_state_nxt = ST_RESP;
            end
            ST_WR: begin
                ram_wen     = !rst;
                ram_waddr   = r_word_addr;
                ram_wdata   = r_wdata;
                w_state_nxt = ST_RESP;
            end
            ST_RMW_RD: begin
                ram_ren     = !rst;
                ram_raddr   = r_word_addr;
                w_state_nxt = ST_RMW_WR;
            end
            ST_RMW_WR: begin
                ram_wen     = !rst;
                ram_waddr   = r_word_addr;
                ram_wdata   = w_merge;
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign ram_ben    = 2'b00;
    assign w_rsp_fire = !rst && (r_state == ST_RESP);
    assign w_rsp_data = (r_err || r_we) ? 32'd0 : w_load;

    assign if_rsp_valid = w_rsp_fire && (r_req == REQ_FETCH);
    assign d_rsp_valid  = w_rsp_fire && (r_req == REQ_DATA);
    assign if_rsp_data  = if_rsp_valid ? w_rsp_data : r_if_data;
    assign if_rsp_err   = if_rsp_valid ? r_err      : r_if_err;
    assign d_rsp_data   = d_rsp_valid  ? w_rsp_data : r_d_data;
    assign d_rsp_err    = d_rsp_valid  ? r_err      : r_d_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= REQ_FETCH;
            r_req        <= REQ_FETCH;
            r_word_addr  <= 16'd0;
            r_offset     <= 2'd0;
            r_size       <= SZ_W;
            r_unsigned   <= 1'b0;
            r_we         <= 1'b0;
            r_err        <= 1'b0;
            r_wdata      <= 32'd0;
            r_if_data    <= 32'd0;
            r_if_err     <= 1'b0;
            r_d_data     <= 32'd0;
            r_d_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_last_grant <= w_grant_d ? REQ_DATA : REQ_FETCH;
                r_req        <= w_grant_d ? REQ_DATA : REQ_FETCH;
                r_word_addr  <= word_addr(w_sel_addr);
                r_offset     <= w_sel_addr[1:0];
                r_size       <= w_sel_size;
                r_unsigned   <= w_grant_d & d_unsigned;
                r_we         <= w_sel_we;
                r_err        <= w_sel_err;
                r_wdata      <= d_wdata;
            end
            if (if_rsp_valid) begin
                r_if_data <= w_rsp_data;
                r_if_err  <= r_err;
            end
            if (d_rsp_valid) begin
                r_d_data <= w_rsp_data;
                r_d_err  <= r_err;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter against a transaction-level model
module tb_mem_arbiter;

    localparam int DEPTH = 2048;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req_valid = 1'b0;
    logic        if_req_ready;
    logic [31:0] if_addr = 32'd0;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        if_rsp_err;
    logic        d_req_valid = 1'b0;
    logic        d_req_ready;
    logic        d_we = 1'b0;
    logic [1:0]  d_size = 2'd0;
    logic        d_unsigned = 1'b0;
    logic [31:0] d_addr = 32'd0;
    logic [31:0] d_wdata = 32'd0;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_data;
    logic        d_rsp_err;
    logic        ram_wen;
    logic        ram_ren;
    logic [1:0]  ram_ben;
    logic [15:0] ram_waddr;
    logic [15:0] ram_raddr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req_valid (if_req_valid),
        .if_req_ready (if_req_ready),
        .if_addr      (if_addr),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_data  (if_rsp_data),
        .if_rsp_err   (if_rsp_err),
        .d_req_valid  (d_req_valid),
        .d_req_ready  (d_req_ready),
        .d_we         (d_we),
        .d_size       (d_size),
        .d_unsigned   (d_unsigned),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_rsp_valid  (d_rsp_valid),
        .d_rsp_data   (d_rsp_data),
        .d_rsp_err    (d_rsp_err),
        .ram_wen      (ram_wen),
        .ram_ren      (ram_ren),
        .ram_ben      (ram_ben),
        .ram_waddr    (ram_waddr),
        .ram_raddr    (ram_raddr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    // RAM macro stand-in: registered read, write on the same edge.
    logic [31:0] ram [DEPTH];
    always @(posedge clk) begin
        if (ram_ren) ram_rdata <= ram[ram_raddr[10:0]];
        if (ram_wen) ram[ram_waddr[10:0]] <= ram_wdata;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the memory contents as the spec says they should be.
    logic [31:0] shadow [DEPTH];

    function automatic logic exp_err(input logic is_d, input logic [1:0] sz, input logic [31:0] a);
        logic bad;
        bad = (a >= 32'(DEPTH * 4));
        if (!is_d) return bad || (a % 4 != 0);
        case (sz)
            2'd0:    return bad;
            2'd1:    return bad || (a % 2 != 0);
            2'd2:    return bad || (a % 4 != 0);
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [31:0] a,
                                             input logic [1:0] sz, input logic uns);
        logic [31:0] v;
        v = w >> (8 * (a % 4));
        if (sz == 2'd0) begin
            v = v & 32'hFF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = v & 32'hFFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] exp_merge(input logic [31:0] w, input logic [31:0] wd,
                                              input logic [31:0] a, input logic [1:0] sz);
        logic [31:0] mask;
        mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << (8 * (a % 4));
        return (w & ~mask) | ((wd << (8 * (a % 4))) & mask);
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          m_free, m_ren_cyc, m_wen_cyc, m_rsp_cyc, m_lat, m_idx;
    logic [15:0] m_raddr, m_waddr;
    logic [31:0] m_wdata, m_rsp_data, m_a;
    logic        m_rsp_err, m_rsp_d, m_lg_data, m_e, m_we;
    logic [1:0]  m_sz;
    logic [31:0] m_if_data, m_d_data;
    logic        m_if_err, m_d_err;
    logic        g_if, g_d, hs_if, hs_d;
    logic        if_seen, d_seen, if_seen_err, d_seen_err;
    logic [31:0] if_seen_data, d_seen_data;
    int          if_seen_cyc, d_seen_cyc, acc_if, acc_d;
    bit          grants[$];

    always @(negedge clk) begin
        if (rst) begin
            check("rst_ren", ram_ren, 1'b0);
            check("rst_wen", ram_wen, 1'b0);
            check("rst_rsp_valid", {if_rsp_valid, d_rsp_valid}, 2'b00);
            check("rst_ready", {if_req_ready, d_req_ready}, 2'b00);
            m_free = cyc + 1; m_lg_data = 1'b0;
            m_ren_cyc = -1; m_wen_cyc = -1; m_rsp_cyc = -1;
            m_if_data = 32'd0; m_if_err = 1'b0; m_d_data = 32'd0; m_d_err = 1'b0;
            hs_if = 1'b0; hs_d = 1'b0;
        end else begin
            g_if = 1'b0; g_d = 1'b0;
            if (cyc >= m_free) begin
                if (if_req_valid && d_req_valid) begin
                    if (m_lg_data) g_if = 1'b1; else g_d = 1'b1;
                end else begin
                    g_if = if_req_valid; g_d = d_req_valid;
                end
            end
            check("if_req_ready", if_req_ready, g_if);
            check("d_req_ready", d_req_ready, g_d);
            hs_if = if_req_valid && if_req_ready;
            hs_d  = d_req_valid && d_req_ready;

            check("ram_ben", ram_ben, 2'b00);
            check("ram_ren", ram_ren, cyc == m_ren_cyc);
            if (ram_ren && cyc == m_ren_cyc) check("ram_raddr", ram_raddr, m_raddr);
            check("ram_wen", ram_wen, cyc == m_wen_cyc);
            if (cyc == m_wen_cyc) begin
                if (ram_wen) begin
                    check("ram_waddr", ram_waddr, m_waddr);
                    check("ram_wdata", ram_wdata, m_wdata);
                end
                shadow[m_waddr[10:0]] = m_wdata;
            end

            if (cyc == m_rsp_cyc && !m_rsp_d) begin m_if_data = m_rsp_data; m_if_err = m_rsp_err; end
            if (cyc == m_rsp_cyc &&  m_rsp_d) begin m_d_data  = m_rsp_data; m_d_err  = m_rsp_err; end
            check("if_rsp_valid", if_rsp_valid, cyc == m_rsp_cyc && !m_rsp_d);
            check("d_rsp_valid",  d_rsp_valid,  cyc == m_rsp_cyc &&  m_rsp_d);
            check("if_rsp_data", if_rsp_data, m_if_data);
            check("if_rsp_err",  if_rsp_err,  m_if_err);
            check("d_rsp_data",  d_rsp_data,  m_d_data);
            check("d_rsp_err",   d_rsp_err,   m_d_err);
            if (if_rsp_valid) begin
                if_seen = 1'b1; if_seen_data = if_rsp_data; if_seen_err = if_rsp_err; if_seen_cyc = cyc;
            end
            if (d_rsp_valid) begin
                d_seen = 1'b1; d_seen_data = d_rsp_data; d_seen_err = d_rsp_err; d_seen_cyc = cyc;
            end

            if (g_if || g_d) begin
                m_a  = g_d ? d_addr : if_addr;
                m_sz = g_d ? d_size : 2'd2;
                m_we = g_d && d_we;
                m_e  = exp_err(g_d, m_sz, m_a);
                m_idx = int'(m_a / 4);
                m_rsp_d = g_d; m_rsp_err = m_e; m_rsp_data = 32'd0;
                if (m_e) begin
                    m_lat = 1;
                end else if (!m_we) begin
                    m_lat = 2; m_ren_cyc = cyc + 1; m_raddr = 16'(m_idx);
                    m_rsp_data = exp_load(shadow[m_idx], m_a, m_sz, g_d && d_unsigned);
                end else if (m_sz == 2'd2) begin
                    m_lat = 2; m_wen_cyc = cyc + 1; m_waddr = 16'(m_idx); m_wdata = d_wdata;
                end else begin
                    m_lat = 3; m_ren_cyc = cyc + 1; m_raddr = 16'(m_idx);
                    m_wen_cyc = cyc + 2; m_waddr = 16'(m_idx);
                    m_wdata = exp_merge(shadow[m_idx], d_wdata, m_a, m_sz);
                end
                m_rsp_cyc = cyc + m_lat;
                m_free    = cyc + m_lat + 1;
                m_lg_data = g_d;
                grants.push_back(g_d);
                if (g_d) acc_d = cyc; else acc_if = cyc;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic is_d, input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] ed,
                          input logic ee, input int lat, input string tag);
        bit ok;
        if (is_d) begin
            d_seen = 1'b0; d_req_valid = 1'b1; d_we = we; d_size = sz;
            d_unsigned = uns; d_addr = a; d_wdata = wd;
        end else begin
            if_seen = 1'b0; if_req_valid = 1'b1; if_addr = a;
        end
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (is_d ? hs_d : hs_if) begin ok = 1'b1; break; end
        end
        check({tag, "_accept"}, 32'(ok), 32'd1);
        if (is_d) d_req_valid = 1'b0; else if_req_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (is_d ? d_seen : if_seen) begin ok = 1'b1; break; end
            step();
        end
        check({tag, "_rsp"}, 32'(ok), 32'd1);
        if (ok) begin
            check({tag, "_lat"}, 32'(is_d ? d_seen_cyc - acc_d : if_seen_cyc - acc_if), 32'(lat));
            check({tag, "_data"}, is_d ? d_seen_data : if_seen_data, ed);
            check({tag, "_err"}, 32'(is_d ? d_seen_err : if_seen_err), 32'(ee));
        end
    endtask

    function automatic logic [31:0] gen_addr(input logic aligned_bias);
        int r;
        r = int'($urandom_range(0, 19));
        if (r == 0) return 32'h2000 + 32'($urandom_range(0, 3));
        if (r == 1) return $urandom;
        if (aligned_bias && r < 14) return 32'($urandom_range(0, 31)) << 2;
        return (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
    endfunction

    logic [31:0] saved;
    bit          ok_rr;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram[i] = $urandom;
            shadow[i] = ram[i];
        end
        ram_rdata = 32'd0;
        repeat (3) step();
        rst = 1'b0;
        step();
        check("post_rst_if_data", if_rsp_data, 32'd0);
        check("post_rst_d_err", 32'(d_rsp_err), 32'd0);

        ram[4] = 32'hDEADBEEF; shadow[4] = 32'hDEADBEEF;
        ram[2] = 32'h11223344; shadow[2] = 32'h11223344;
        do_req(1'b0, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0, 2, "fetch10");
        do_req(1'b1, 1'b1, 2'd0, 1'b0, 32'h9, 32'hAB, 32'd0, 1'b0, 3, "sb9");
        check("sb9_mem", ram[2], 32'h1122AB44);
        do_req(1'b1, 1'b1, 2'd2, 1'b0, 32'h8, 32'h1180AB44, 32'd0, 1'b0, 2, "sw8");
        do_req(1'b1, 1'b0, 2'd0, 1'b0, 32'hA, 32'd0, 32'hFFFFFF80, 1'b0, 2, "lb_a");
        do_req(1'b1, 1'b0, 2'd0, 1'b1, 32'hA, 32'd0, 32'h00000080, 1'b0, 2, "lbu_a");
        do_req(1'b1, 1'b0, 2'd1, 1'b0, 32'h8, 32'd0, 32'hFFFFAB44, 1'b0, 2, "lh_8");
        do_req(1'b1, 1'b1, 2'd2, 1'b0, 32'h2, 32'h5, 32'd0, 1'b1, 1, "sw_mis");
        do_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h2000, 32'd0, 32'd0, 1'b1, 1, "lw_oor");
        do_req(1'b1, 1'b0, 2'd3, 1'b0, 32'h0, 32'd0, 32'd0, 1'b1, 1, "sz11");
        do_req(1'b0, 1'b0, 2'd2, 1'b0, 32'h6, 32'd0, 32'd0, 1'b1, 1, "fetch_mis");

        // Reset landing on the RMW write cycle must abort the store silently.
        saved = ram[5];
        d_seen = 1'b0; d_req_valid = 1'b1; d_we = 1'b1; d_size = 2'd0;
        d_unsigned = 1'b0; d_addr = 32'h15; d_wdata = 32'h55;
        ok_rr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (hs_d) begin ok_rr = 1'b1; break; end
        end
        check("rmwrst_accept", 32'(ok_rr), 32'd1);
        d_req_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rmwrst_mem", ram[5], saved);
        do_req(1'b0, 1'b0, 2'd2, 1'b0, 32'h14, 32'd0, saved, 1'b0, 2, "rmwrst_fetch");
        check("rmwrst_no_rsp", 32'(d_seen), 32'd0);

        // Both requesters valid straight out of reset: grants alternate starting with data.
        rst = 1'b1;
        if_req_valid = 1'b1; if_addr = 32'h0;
        d_req_valid = 1'b1; d_we = 1'b0; d_size = 2'd2; d_unsigned = 1'b0; d_addr = 32'h4;
        repeat (2) step();
        grants.delete();
        rst = 1'b0;
        repeat (30) step();
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        repeat (6) step();
        check("alt_count", 32'(grants.size() >= 4), 32'd1);
        if (grants.size() >= 4) begin
            check("alt_g0", 32'(grants[0]), 32'd1);
            check("alt_g1", 32'(grants[1]), 32'd0);
            check("alt_g2", 32'(grants[2]), 32'd1);
            check("alt_g3", 32'(grants[3]), 32'd0);
        end

        for (int c = 0; c < 1500; c++) begin
            if (!if_req_valid || hs_if) begin
                if_req_valid = ($urandom_range(0, 2) != 0);
                if_addr = gen_addr(1'b1);
            end
            if (!d_req_valid || hs_d) begin
                d_req_valid = ($urandom_range(0, 2) != 0);
                d_we = $urandom_range(0, 1) == 1;
                d_size = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                d_unsigned = $urandom_range(0, 1) == 1;
                d_addr = gen_addr(1'b0);
                d_wdata = $urandom;
            end
            step();
        end
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        repeat (8) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
